// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, drives the datapath strobes and counts retired instructions.
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter logic [OPCODE_W-1:0] OP_RTYPE = 0,
    parameter logic [OPCODE_W-1:0] OP_LW    = 35,
    parameter logic [OPCODE_W-1:0] OP_SW    = 43,
    parameter logic [OPCODE_W-1:0] OP_BEQ   = 4,
    parameter logic [OPCODE_W-1:0] OP_ADDI  = 8,
    parameter logic [OPCODE_W-1:0] OP_J     = 2,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    instr_retired,
    output logic [3:0]          state_dbg
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        EXECUTE, R_WB, BRANCH, ADDI_EXEC, ADDI_WB, JUMP, TRAP
    } state_t;

    state_t state, state_next;
    logic   retire;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= FETCH;
            instr_retired <= '0;
        end else begin
            state <= state_next;
            if (retire)
                instr_retired <= instr_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Memory handshake: a request (mem_read or mem_write) is held with a stable
    // address select until the cycle mem_ready is high; that cycle completes it.
    always_comb begin
        state_next    = state;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        illegal_op    = 1'b0;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'd3;
                if (opcode == OP_LW || opcode == OP_SW) state_next = MEM_ADDR;
                else if (opcode == OP_RTYPE)            state_next = EXECUTE;
                else if (opcode == OP_BEQ)              state_next = BRANCH;
                else if (opcode == OP_ADDI)             state_next = ADDI_EXEC;
                else if (opcode == OP_J)                state_next = JUMP;
                else                                    state_next = TRAP;
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_next = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'd2;
                state_next = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                retire        = 1'b1;
                state_next    = FETCH;
            end
            ADDI_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                state_next = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'd2;
                retire     = 1'b1;
                state_next = FETCH;
            end
            TRAP: begin
                illegal_op = 1'b1;
            end
            default: state_next = FETCH;
        endcase
        // Reset silences every strobe regardless of the (possibly stale) state.
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'd0;
            alu_op        = 2'd0;
            pc_source     = 2'd0;
            illegal_op    = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control unit for the multi-cycle MIPS datapath, the next generation after the combinational single-cycle opcode decoder. A Moore-style FSM steps each instruction through fetch, decode, execute, memory and write-back, and asserts per-cycle datapath strobes. A mem_ready handshake supports variable-latency memory. Adds ADDI and J, traps illegal opcodes, and counts retired instructions. Sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

Parameters:
OPCODE_W, 6, opcode field width
OP_RTYPE, 0, R-type opcode
OP_LW, 35, load word opcode
OP_SW, 43, store word opcode
OP_BEQ, 4, branch-equal opcode
OP_ADDI, 8, add-immediate opcode
OP_J, 2, jump opcode
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  OPCODE_W  opcode from instruction register; valid from DECODE onward
mem_ready  in  1  memory completes the current read or write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (branch)
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load instruction register
mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR
reg_dst  out  1  destination select: 0 = rt, 1 = rd
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A select: 0 = PC, 1 = reg A
alu_src_b  out  2  ALU B select: 0 = reg B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2
alu_op  out  2  ALU op class: 0 = add, 1 = sub, 2 = use funct
pc_source  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target
illegal_op  out  1  high while in TRAP
instr_retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (rst_n=0 at a clock edge): state <= FETCH, instr_retired <= 0. While rst_n=0, all strobe outputs and illegal_op are forced to 0. Reset mid-instruction aborts that instruction with no retire.
- Outputs are combinational from state. Exceptions: ir_write and pc_write in FETCH also require mem_ready. Any strobe not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0. ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut). Next state by opcode: LW/SW -> MEM_ADDR; RTYPE -> EXECUTE; BEQ -> BRANCH; ADDI -> ADDI_EXEC; J -> JUMP; any other opcode -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next is MEM_RD for LW, MEM_WR for SW (opcode held stable by the IR).
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Retires; next FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then retires; next FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=0, alu_op=2. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retires; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Retires whether or not taken; next FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=2, alu_op=0. Next ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Retires; next FETCH.
- JUMP: pc_write=1, pc_source=2. Retires; next FETCH.
- TRAP: illegal_op=1, all strobes 0. Absorbing; exited only by reset. No retire.
- Retire: instr_retired increments by 1 on the clock edge leaving a retiring state. Wraps modulo 2^CNT_W with no saturation.
- Latency with mem_ready held 1: LW 5 cycles; SW 4; R-type 4; ADDI 4; BEQ 3; J 3. Each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds 1 cycle. mem_ready is ignored in all other states.
- Waiting states hold mem_read/mem_write/i_or_d stable until the mem_ready cycle inclusive. mem_read and mem_write are never both high.

Test Plan:
- Reset then R-type (opcode 0), mem_ready=1 -> states FETCH, DECODE, EXECUTE, R_WB; reg_write=1 and reg_dst=1 only in cycle 4; instr_retired 0->1.
- LW (35) with mem_ready low for 2 cycles in FETCH and 3 in MEM_RD -> total 10 cycles; ir_write high exactly once; mem_to_reg=1 with reg_write=1 in final cycle.
- SW (43) then BEQ (4) then J (2), mem_ready=1 -> 4+3+3 cycles; mem_write=1 one cycle; pc_write_cond=1 with pc_source=1 in BEQ; pc_write=1 with pc_source=2 in JUMP; instr_retired=3.
- ADDI (8) -> alu_src_b=2 in ADDI_EXEC; reg_write=1, reg_dst=0 in ADDI_WB; 4 cycles.
- Illegal opcode 63 -> TRAP after DECODE; illegal_op=1 indefinitely, all strobes 0, counter frozen; rst_n=0 for one edge -> FETCH, illegal_op=0, counter 0.
- CNT_W=4, 16 back-to-back J instructions -> instr_retired wraps 15->0. rst_n=0 asserted in MEM_RD -> next state FETCH, no retire.
